// File: rtl/isp_tpg_pkg.sv
// isp_tpg_pkg: shared FSM states, pattern codes, bar colour table and Bayer lookup for the raw TPG.
package isp_tpg_pkg;

    typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE, S_HBLANK} tpg_state_t;
    typedef enum logic [1:0] {PAT_GRAY, PAT_BARS, PAT_RAMP, PAT_LFSR} tpg_pattern_t;
    typedef enum logic [1:0] {COL_R, COL_GR, COL_GB, COL_B} bayer_col_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // {R,G,B} per bar, element 0 is the leftmost (white) bar
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    // Every supported order is the RGGB map with {y[0],x[0]} xor'ed by the order code
    function automatic bayer_col_t bayer_color(input logic [1:0] bayer, input logic y0, input logic x0);
        return bayer_col_t'({y0, x0} ^ bayer);
    endfunction

    function automatic logic bar_hit(input logic [2:0] idx, input bayer_col_t col);
        logic [2:0] rgb;
        rgb = BAR_RGB[idx];
        return col == COL_R ? rgb[2] : col == COL_B ? rgb[0] : rgb[1];
    endfunction

endpackage

// File: rtl/isp_tpg_lfsr.sv
// isp_tpg_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11); value shows the seed while seed_load is high.
module isp_tpg_lfsr
    import isp_tpg_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] q;

    assign value = seed_load ? LFSR_SEED : q;

    always_ff @(posedge pclk) begin
        if (rst)
            q <= LFSR_SEED;
        else
            q <= advance ? {value[0] ^ value[2] ^ value[3] ^ value[5], value[15:1]} : value;
    end

endmodule

// File: rtl/isp_raw_tpg.sv
// isp_raw_tpg: raw Bayer test-pattern generator producing vsync/href/raw frames with programmable geometry.
module isp_raw_tpg
    import isp_tpg_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1936,
    parameter int HEIGHT = 960,
    parameter int HBLANK = 64,
    parameter int VBLANK = 16,
    parameter int BAYER  = 2
)(
    input  logic            pclk,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      pattern,
    output logic            out_vsync,
    output logic            out_href,
    output logic [BITS-1:0] out_raw,
    output logic            frame_start
);

    localparam int XW = $clog2(WIDTH + HBLANK);
    localparam int YW = $clog2(HEIGHT + VBLANK);
    localparam int BW = WIDTH / 8;
    localparam int CW = $clog2(BW + 1);
    localparam logic [XW-1:0] X_ACT_END = XW'(WIDTH - 1);
    localparam logic [XW-1:0] X_HB_END  = XW'(HBLANK - 1);
    localparam logic [XW-1:0] X_VB_END  = XW'(WIDTH + HBLANK - 1);
    localparam logic [YW-1:0] Y_ACT_END = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_VB_END  = YW'(VBLANK - 1);
    localparam logic [CW-1:0] C_END     = CW'(BW - 1);

    tpg_state_t   state, nxt_state;
    tpg_pattern_t pat;
    bayer_col_t   col;
    logic [XW-1:0]   x, nxt_x;
    logic [YW-1:0]   y, nxt_y;
    logic [CW-1:0]   bar_cnt, nxt_cnt;
    logic [2:0]      bar_idx, nxt_idx;
    logic            fs_nxt, line_start;
    logic [15:0]     lfsr_val;
    logic [BITS-1:0] nxt_raw;

    // x/y are reused as blank-line position and line counter during VBLANK
    always_comb begin
        nxt_state = state;
        nxt_x = x + XW'(1);
        nxt_y = y;
        case (state)
            S_IDLE: begin
                nxt_x = '0;
                nxt_y = '0;
                nxt_state = enable ? S_VBLANK : S_IDLE;
            end
            S_VBLANK: if (x == X_VB_END) begin
                nxt_x = '0;
                nxt_y = y == Y_VB_END ? '0 : y + YW'(1);
                nxt_state = y == Y_VB_END ? S_ACTIVE : S_VBLANK;
            end
            S_ACTIVE: if (x == X_ACT_END) begin
                nxt_x = '0;
                nxt_state = S_HBLANK;
            end
            S_HBLANK: if (x == X_HB_END) begin
                nxt_x = '0;
                nxt_y = y == Y_ACT_END ? '0 : y + YW'(1);
                nxt_state = y != Y_ACT_END ? S_ACTIVE : enable ? S_VBLANK : S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Everything below describes the pixel that will be on the outputs after the next edge
    always_comb begin
        fs_nxt = state == S_VBLANK && nxt_state == S_ACTIVE;
        line_start = nxt_state == S_ACTIVE && state != S_ACTIVE;
        nxt_cnt = line_start || bar_cnt == C_END ? '0 : bar_cnt + CW'(1);
        nxt_idx = line_start ? '0 : bar_cnt == C_END && bar_idx != 3'd7 ? bar_idx + 3'd1 : bar_idx;
        col = bayer_color(2'(BAYER), nxt_y[0], nxt_x[0]);
        nxt_raw = nxt_state != S_ACTIVE ? '0 :
                  pat == PAT_GRAY ? {1'b1, {(BITS-1){1'b0}}} :
                  pat == PAT_BARS ? {BITS{bar_hit(nxt_idx, col)}} :
                  pat == PAT_RAMP ? BITS'(nxt_x) : BITS'(lfsr_val);
    end

    isp_tpg_lfsr u_lfsr (
        .pclk      (pclk),
        .rst       (rst),
        .seed_load (fs_nxt),
        .advance   (nxt_state == S_ACTIVE),
        .value     (lfsr_val)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= S_IDLE;
            pat <= PAT_GRAY;
            x <= '0;
            y <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            out_vsync <= 1'b0;
            out_href <= 1'b0;
            out_raw <= '0;
            frame_start <= 1'b0;
        end else begin
            state <= nxt_state;
            pat <= nxt_state == S_VBLANK && state != S_VBLANK ? tpg_pattern_t'(pattern) : pat;
            x <= nxt_x;
            y <= nxt_y;
            bar_cnt <= nxt_cnt;
            bar_idx <= nxt_idx;
            out_vsync <= nxt_state == S_VBLANK;
            out_href <= nxt_state == S_ACTIVE;
            out_raw <= nxt_raw;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_isp_raw_tpg.sv
// tb_isp_raw_tpg: directed checks of frame geometry, patterns, enable drop and reset for a 16x4 RGGB frame.
module tb_isp_raw_tpg;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic       out_vsync, out_href, frame_start;
    logic [7:0] out_raw;
    int         checks = 0;
    int         errors = 0;

    localparam logic [7:0] BAR_L0 [16] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255,
                                           8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [7:0] BAR_L1 [16] = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0,
                                           8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};
    localparam logic [7:0] LFSR_EXP [4] = '{8'hE1, 8'h70, 8'h38, 8'h9C};

    always #5 pclk = ~pclk;

    isp_raw_tpg #(
        .BITS(8), .WIDTH(16), .HEIGHT(4), .HBLANK(4), .VBLANK(2), .BAYER(0)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .enable      (enable),
        .pattern     (pattern),
        .out_vsync   (out_vsync),
        .out_href    (out_href),
        .out_raw     (out_raw),
        .frame_start (frame_start)
    );

    task automatic restart(input logic [1:0] pat);
        @(negedge pclk);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge pclk);
        rst = 1'b0;
        pattern = pat;
        enable = 1'b1;
    endtask

    task automatic wait_fs(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge pclk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s frame_start: no pulse within 400 cycles, required a pulse", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            checks++;
            if ({out_vsync, out_href, frame_start, out_raw} !== 11'd0) begin
                errors++;
                $display("FAIL reset outputs: got %h, required 0", {out_vsync, out_href, frame_start, out_raw});
            end
        end
        rst = 1'b0;
        repeat (50) begin
            @(negedge pclk);
            checks++;
            if ({out_vsync, out_href, frame_start, out_raw} !== 11'd0) begin
                errors++;
                $display("FAIL idle outputs: got %h, required 0", {out_vsync, out_href, frame_start, out_raw});
            end
        end
    endtask

    task automatic test_geometry;
        logic [10:0] exp;
        int p;
        restart(2'd0);
        for (int k = 0; k < 240; k++) begin
            @(negedge pclk);
            p = k % 120;
            exp[10] = p < 40;
            exp[9] = p >= 40 && ((p - 40) % 20) < 16;
            exp[8] = p == 40;
            exp[7:0] = exp[9] ? 8'd128 : 8'd0;
            checks++;
            if ({out_vsync, out_href, frame_start, out_raw} !== exp) begin
                errors++;
                $display("FAIL geometry cycle %0d: {vsync,href,fs,raw} got %h, required %h",
                         k, {out_vsync, out_href, frame_start, out_raw}, exp);
            end
        end
    endtask

    task automatic test_bars;
        restart(2'd1);
        wait_fs("bars");
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (out_href !== 1'b1 || out_raw !== (ln == 0 ? BAR_L0[i] : BAR_L1[i])) begin
                    errors++;
                    $display("FAIL bars line %0d px %0d: href=%b raw=%0d, required href=1 raw=%0d",
                             ln, i, out_href, out_raw, ln == 0 ? BAR_L0[i] : BAR_L1[i]);
                end
                @(negedge pclk);
            end
            repeat (4) begin
                checks++;
                if (out_href !== 1'b0 || out_raw !== 8'd0) begin
                    errors++;
                    $display("FAIL bars hblank line %0d: href=%b raw=%0d, required 0 0", ln, out_href, out_raw);
                end
                @(negedge pclk);
            end
        end
    endtask

    task automatic test_ramp;
        restart(2'd2);
        wait_fs("ramp");
        for (int ln = 0; ln < 4; ln++) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (out_href !== 1'b1 || out_raw !== 8'(i)) begin
                    errors++;
                    $display("FAIL ramp line %0d px %0d: href=%b raw=%0d, required href=1 raw=%0d",
                             ln, i, out_href, out_raw, i);
                end
                @(negedge pclk);
            end
            repeat (4) begin
                checks++;
                if (out_href !== 1'b0 || out_raw !== 8'd0) begin
                    errors++;
                    $display("FAIL ramp hblank line %0d: href=%b raw=%0d, required 0 0", ln, out_href, out_raw);
                end
                @(negedge pclk);
            end
        end
    endtask

    task automatic test_lfsr;
        restart(2'd3);
        for (int f = 0; f < 2; f++) begin
            wait_fs("lfsr");
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_raw !== LFSR_EXP[i]) begin
                    errors++;
                    $display("FAIL lfsr frame %0d px %0d: raw=%h, required %h", f, i, out_raw, LFSR_EXP[i]);
                end
                @(negedge pclk);
            end
        end
    endtask

    task automatic test_enable_drop;
        restart(2'd1);
        wait_fs("drop");
        repeat (20) @(negedge pclk);
        enable = 1'b0;
        pattern = 2'd2;
        for (int ln = 1; ln < 4; ln++) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (out_href !== 1'b1 || out_raw !== (ln % 2 == 0 ? BAR_L0[i] : BAR_L1[i])) begin
                    errors++;
                    $display("FAIL drop line %0d px %0d: href=%b raw=%0d, required href=1 raw=%0d",
                             ln, i, out_href, out_raw, ln % 2 == 0 ? BAR_L0[i] : BAR_L1[i]);
                end
                @(negedge pclk);
            end
            repeat (4) @(negedge pclk);
        end
        repeat (130) begin
            checks++;
            if ({out_vsync, out_href, frame_start, out_raw} !== 11'd0) begin
                errors++;
                $display("FAIL drop idle: got %h, required 0", {out_vsync, out_href, frame_start, out_raw});
            end
            @(negedge pclk);
        end
    endtask

    task automatic test_rst_mid_line;
        restart(2'd2);
        wait_fs("rst_mid");
        repeat (5) @(negedge pclk);
        checks++;
        if (out_href !== 1'b1 || out_raw !== 8'd5) begin
            errors++;
            $display("FAIL rst_mid pre: href=%b raw=%0d, required 1 5", out_href, out_raw);
        end
        rst = 1'b1;
        enable = 1'b0;
        @(negedge pclk);
        checks++;
        if ({out_vsync, out_href, frame_start, out_raw} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid next cycle: got %h, required 0", {out_vsync, out_href, frame_start, out_raw});
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge pclk);
            checks++;
            if ({out_vsync, out_href, frame_start, out_raw} !== 11'd0) begin
                errors++;
                $display("FAIL rst_mid after: got %h, required 0", {out_vsync, out_href, frame_start, out_raw});
            end
        end
    endtask

    initial begin
        test_reset();
        test_geometry();
        test_bars();
        test_ramp();
        test_lfsr();
        test_enable_drop();
        test_rst_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
